mult_pipe: RTL and testbench
============================

MULT_PIPE -- requirements
Module: mult_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have parameter NUM_STAGES, default 4: pipeline depth; legal values 1, 2, 4, 8, each dividing 2*XLEN.
REQ-003 SHALL have parameter TAG_W, default 5: ROB tag width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports clock, input, 1: rising-edge clock.
REQ-006 SHALL have ports reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have ports in_valid, input, 1, and in_ready, output, 1: issue handshake.
REQ-008 SHALL have port in_func, input, 2: MUL=0, MULH=1, MULHSU=2, MULHU=3.
REQ-009 SHALL have ports in_opa, input, XLEN, and in_opb, input, XLEN: rs1 and rs2 values.
REQ-010 SHALL have ports in_tag, input, TAG_W, and in_spec, input, 1: ROB tag and speculative flag.
REQ-011 SHALL have ports squash, input, 1, and resolve, input, 1: branch mispredict and branch correct.
REQ-012 SHALL have ports out_valid, output, 1, and out_ready, input, 1: writeback handshake.
REQ-013 SHALL have ports out_value, output, XLEN; out_tag, output, TAG_W; out_spec, output, 1.
REQ-014 SHALL have port busy, output, 1: any stage holds a valid entry.

Function
REQ-015 SHALL accept an entry at a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL set advance = !out_valid | out_ready, and SHALL drive in_ready = advance, combinationally.
REQ-017 SHALL shift all stages in lockstep when advance=1, and SHALL hold every stage (global stall, no bubble collapse) when advance=0.
REQ-018 SHALL assert out_valid exactly NUM_STAGES cycles after acceptance when no stall occurs; throughput is 1 per cycle.
REQ-019 SHALL keep out_value, out_tag and out_spec stable while out_valid=1 and out_ready=0.
REQ-020 SHALL extend operands to 2*XLEN: opa is signed for MULH and MULHSU, opb is signed for MULH only, all others zero-extended.
REQ-021 SHALL form product P = low 2*XLEN bits of ext(opa)*ext(opb), with each stage consuming 2*XLEN/NUM_STAGES multiplier bits.
REQ-022 SHALL output P[XLEN-1:0] for MUL, and P[2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-023 SHALL preserve issue order; tag and func travel with their entry.
REQ-024 On squash=1, SHALL invalidate at that edge every in-flight entry with spec=1, and SHALL discard an entry accepted that cycle with in_spec=1; non-spec entries are unaffected.
REQ-025 During a squash cycle, SHALL treat out_valid with out_spec=1 as void, so the consumer ignores it.
REQ-026 On resolve=1, SHALL clear spec on all in-flight entries and on an entry accepted that cycle.
REQ-027 When squash and resolve are both 1 in the same cycle, squash SHALL win.
REQ-028 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-029 On reset, SHALL clear all stage valid bits and set out_valid=0, out_value=0, out_tag=0, out_spec=0, busy=0.
REQ-030 SHALL have in_ready=1 in the first cycle after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight entries with no output produced.
REQ-032 Reset SHALL take priority over squash, resolve and accept.

Structure
REQ-033 SHALL place the MULT_FUNC enum in the shared package; XLEN defaults come from the package `XLEN.
REQ-034 SHALL use one sub-module, mult_pipe_stage (partial-product accumulate plus valid/tag/spec/func registers), instantiated NUM_STAGES times.

Verification
Scenarios use XLEN=32, NUM_STAGES=4.
REQ-035 MUL 7 x 0xFFFFFFFD, tag 3 -> out_valid 4 cycles later, out_value 0xFFFFFFEB, out_tag 3.
REQ-036 MULH 0x80000000x0x80000000 -> 0x40000000; MULHU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFFx0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 Four back-to-back issues, tags 1-4, out_ready=0 for 3 cycles at the first result -> in_ready=0 during the stall, outputs held, tags 1,2,3,4 retire in order, none lost.
REQ-038 Tags 1(spec=0), 2(spec=1), 3(spec=0) in flight, squash one cycle -> only tags 1 and 3 emerge.
REQ-039 Tag 5 spec=1, resolve then squash next cycle -> tag 5 emerges with out_spec=0.
REQ-040 Reset asserted with 3 entries in flight -> no out_valid afterwards; busy=0 and in_ready=1 the cycle after reset.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// Shared types and defaults for the pipelined RISC-V M-extension multiplier.
package mult_pipe_pkg;

    localparam int unsigned DefaultXlen = 32;

    typedef enum logic [1:0] {
        FuncMul    = 2'd0,
        FuncMulh   = 2'd1,
        FuncMulhsu = 2'd2,
        FuncMulhu  = 2'd3
    } mult_func_e;

    function automatic logic opa_signed(mult_func_e f);
        return (f == FuncMulh) || (f == FuncMulhsu);
    endfunction

    function automatic logic opb_signed(mult_func_e f);
        return f == FuncMulh;
    endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Issue, writeback and branch-control signals between the core and the multiplier.
interface mult_pipe_if
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = DefaultXlen,
    parameter int unsigned TAG_W = 5
) ();

    logic             in_valid;
    logic             in_ready;
    mult_func_e       in_func;
    logic [XLEN-1:0]  in_opa;
    logic [XLEN-1:0]  in_opb;
    logic [TAG_W-1:0] in_tag;
    logic             in_spec;
    logic             squash;
    logic             resolve;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_value;
    logic [TAG_W-1:0] out_tag;
    logic             out_spec;
    logic             busy;

    modport master (
        output in_valid, in_func, in_opa, in_opb, in_tag, in_spec, squash, resolve, out_ready,
        input  in_ready, out_valid, out_value, out_tag, out_spec, busy
    );

    modport slave (
        input  in_valid, in_func, in_opa, in_opb, in_tag, in_spec, squash, resolve, out_ready,
        output in_ready, out_valid, out_value, out_tag, out_spec, busy
    );

endinterface

// File: rtl/mult_pipe_stage.sv
// One multiplier stage: accumulates the partial product for its slice of the multiplier
// and carries the entry's valid/tag/spec/func alongside.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = DefaultXlen,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CHUNK = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic              squash_i,
    input  logic              resolve_i,
    input  logic              valid_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              spec_i,
    input  mult_func_e        func_i,
    input  logic [2*XLEN-1:0] opa_i,
    input  logic [2*XLEN-1:0] opb_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic              valid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              spec_o,
    output mult_func_e        func_o,
    output logic [2*XLEN-1:0] opa_o,
    output logic [2*XLEN-1:0] opb_o,
    output logic [2*XLEN-1:0] acc_o
);

    localparam int unsigned PW = 2 * XLEN;

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             spec_q, spec_d;
    mult_func_e       func_q, func_d;
    logic [PW-1:0]    opa_q, opa_d;
    logic [PW-1:0]    opb_q, opb_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    chunk_ext;
    logic [PW-1:0]    partial;

    // Multiplier slice is taken unsigned; the product is only kept modulo 2^PW.
    always_comb begin
        chunk_ext            = '0;
        chunk_ext[CHUNK-1:0] = opb_i[SHIFT +: CHUNK];
    end

    assign partial = (opa_i * chunk_ext) << SHIFT;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        spec_d  = spec_q;
        func_d  = func_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        if (advance_i) begin
            valid_d = valid_i;
            tag_d   = tag_i;
            spec_d  = spec_i;
            func_d  = func_i;
            opa_d   = opa_i;
            opb_d   = opb_i;
            acc_d   = acc_i + partial;
        end
        // Squash outranks resolve: a speculative entry dies before it can be confirmed.
        if (squash_i && spec_d) begin
            valid_d = 1'b0;
        end else if (resolve_i) begin
            spec_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            spec_q  <= 1'b0;
            func_q  <= FuncMul;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            spec_q  <= spec_d;
            func_q  <= func_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
        end
    end

    assign valid_o = valid_q;
    assign tag_o   = tag_q;
    assign spec_o  = spec_q;
    assign func_o  = func_q;
    assign opa_o   = opa_q;
    assign opb_o   = opb_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with lockstep stall and speculative squash/resolve.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = DefaultXlen,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned TAG_W      = 5
) (
    input logic        clock,
    input logic        reset,
    mult_pipe_if.slave bus
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CHUNK = PW / NUM_STAGES;

    // Index 0 is the issue port, index s+1 is the register output of stage s.
    logic                advance;
    logic [NUM_STAGES:0] valid;
    logic [NUM_STAGES:0] spec;
    logic [TAG_W-1:0]    tag  [NUM_STAGES+1];
    mult_func_e          func [NUM_STAGES+1];
    logic [PW-1:0]       opa  [NUM_STAGES+1];
    logic [PW-1:0]       opb  [NUM_STAGES+1];
    logic [PW-1:0]       acc  [NUM_STAGES+1];

    assign advance = !valid[NUM_STAGES] || bus.out_ready;

    assign valid[0] = bus.in_valid;
    assign spec[0]  = bus.in_spec;
    assign tag[0]   = bus.in_tag;
    assign func[0]  = bus.in_func;
    assign opa[0]   = {{XLEN{opa_signed(bus.in_func) & bus.in_opa[XLEN-1]}}, bus.in_opa};
    assign opb[0]   = {{XLEN{opb_signed(bus.in_func) & bus.in_opb[XLEN-1]}}, bus.in_opb};
    assign acc[0]   = '0;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        mult_pipe_stage #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .CHUNK (CHUNK),
            .SHIFT (s * CHUNK)
        ) u_stage (
            .clk_i     (clock),
            .rst_i     (reset),
            .advance_i (advance),
            .squash_i  (bus.squash),
            .resolve_i (bus.resolve),
            .valid_i   (valid[s]),
            .tag_i     (tag[s]),
            .spec_i    (spec[s]),
            .func_i    (func[s]),
            .opa_i     (opa[s]),
            .opb_i     (opb[s]),
            .acc_i     (acc[s]),
            .valid_o   (valid[s+1]),
            .tag_o     (tag[s+1]),
            .spec_o    (spec[s+1]),
            .func_o    (func[s+1]),
            .opa_o     (opa[s+1]),
            .opb_o     (opb[s+1]),
            .acc_o     (acc[s+1])
        );
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid[NUM_STAGES];
    assign bus.out_tag   = tag[NUM_STAGES];
    assign bus.out_spec  = spec[NUM_STAGES];
    assign bus.out_value = (func[NUM_STAGES] == FuncMul) ? acc[NUM_STAGES][XLEN-1:0]
                                                         : acc[NUM_STAGES][PW-1:XLEN];
    assign bus.busy      = |valid[NUM_STAGES:1];

    // Operands are dead once the last slice has been accumulated.
    logic unused_tail;
    assign unused_tail = ^{opa[NUM_STAGES], opb[NUM_STAGES]};

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed scenarios plus a randomized queue-model run.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NS   = 4;
    localparam int unsigned TW   = 5;

    typedef struct {
        logic [TW-1:0]   tag;
        logic            spec;
        logic [XLEN-1:0] val;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_pipe_if #(.XLEN(XLEN), .TAG_W(TW)) bus ();

    mult_pipe #(.XLEN(XLEN), .NUM_STAGES(NS), .TAG_W(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Direct 64-bit product with operand signedness chosen by the instruction.
    function automatic logic [31:0] ref_mul(mult_func_e f, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f == FuncMulh || f == FuncMulhsu) ? 64'($signed(a)) : {32'h0, a};
        eb = (f == FuncMulh) ? 64'($signed(b)) : {32'h0, b};
        p  = ea * eb;
        return (f == FuncMul) ? p[31:0] : p[63:32];
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_func   = FuncMul;
        bus.in_opa    = '0;
        bus.in_opb    = '0;
        bus.in_tag    = '0;
        bus.in_spec   = 1'b0;
        bus.squash    = 1'b0;
        bus.resolve   = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic set_issue(mult_func_e f, logic [31:0] a, logic [31:0] b, logic [TW-1:0] t,
                             logic s);
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_opa   = a;
        bus.in_opb   = b;
        bus.in_tag   = t;
        bus.in_spec  = s;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out_value !== 32'h0) begin
            errors++; $display("FAIL reset_out_value got %h want 0", bus.out_value);
        end
        checks++;
        if (bus.out_tag !== 5'd0) begin
            errors++; $display("FAIL reset_out_tag got %0d want 0", bus.out_tag);
        end
        checks++;
        if (bus.out_spec !== 1'b0) begin
            errors++; $display("FAIL reset_out_spec got %b want 0", bus.out_spec);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clock);
        set_issue(FuncMul, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0);
        #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            checks++;
            if (bus.out_valid !== (c == 4)) begin
                errors++;
                $display("FAIL latency_c%0d out_valid got %b want %b", c, bus.out_valid, c == 4);
            end
        end
        checks++;
        if (bus.out_value !== 32'hFFFF_FFEB || bus.out_tag !== 5'd3) begin
            errors++;
            $display("FAIL latency_result got %h/tag %0d want ffffffeb/tag 3", bus.out_value,
                     bus.out_tag);
        end
    endtask

    task automatic test_funcs();
        mult_func_e  fs  [3] = '{FuncMulh, FuncMulhu, FuncMulhsu};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            logic got;
            @(negedge clock);
            set_issue(fs[i], as[i], as[i], 5'(i + 8), 1'b0);
            #1;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clock);
                idle_inputs();
                #1;
                got = bus.out_valid;
            end
            checks++;
            if (!got || bus.out_value !== exp[i]) begin
                errors++;
                $display("FAIL func_%s got valid=%b value=%h want %h", fs[i].name(), got,
                         bus.out_value, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev [4];
        int          idx;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            mult_func_e  f;
            a = $urandom;
            b = $urandom;
            f = mult_func_e'($urandom_range(0, 3));
            ev[i] = ref_mul(f, a, b);
            @(negedge clock);
            set_issue(f, a, b, 5'(i + 1), 1'b0);
            #1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            idle_inputs();
            bus.out_ready = 1'b0;
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready c%0d got %b want 0", c, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1 || bus.out_value !== ev[0]) begin
                errors++;
                $display("FAIL stall_hold c%0d got v=%b tag=%0d val=%h want v=1 tag=1 val=%h", c,
                         bus.out_valid, bus.out_tag, bus.out_value, ev[0]);
            end
        end
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_tag !== 5'(idx + 1) || bus.out_value !== ev[idx]) begin
                    errors++;
                    $display("FAIL b2b_order got tag=%0d val=%h want tag=%0d val=%h",
                             bus.out_tag, bus.out_value, idx + 1, ev[idx]);
                end
                idx++;
            end
        end
        checks++;
        if (idx != 4) begin
            errors++; $display("FAIL b2b_count got %0d want 4", idx);
        end
    endtask

    task automatic test_squash();
        logic [TW-1:0] seen [4];
        int            n;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            set_issue(FuncMul, $urandom, $urandom, 5'(i + 1), i == 1);
            #1;
        end
        @(negedge clock);
        idle_inputs();
        bus.squash = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (bus.out_valid && n < 4) begin
                seen[n] = bus.out_tag;
                n++;
            end
        end
        checks++;
        if (n != 2 || seen[0] !== 5'd1 || seen[1] !== 5'd3) begin
            errors++;
            $display("FAIL squash_survivors got count=%0d first=%0d second=%0d want 2,1,3", n,
                     seen[0], seen[1]);
        end
    endtask

    task automatic test_resolve();
        int   n;
        logic spec_seen;
        logic [TW-1:0] tag_seen;
        @(negedge clock);
        set_issue(FuncMul, 32'd5, 32'd6, 5'd5, 1'b1);
        #1;
        @(negedge clock);
        idle_inputs();
        bus.resolve = 1'b1;
        #1;
        @(negedge clock);
        idle_inputs();
        bus.squash = 1'b1;
        #1;
        n = 0;
        spec_seen = 1'b1;
        tag_seen  = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (bus.out_valid) begin
                n++;
                spec_seen = bus.out_spec;
                tag_seen  = bus.out_tag;
            end
        end
        checks++;
        if (n != 1 || tag_seen !== 5'd5 || spec_seen !== 1'b0) begin
            errors++;
            $display("FAIL resolve_then_squash got count=%0d tag=%0d spec=%b want 1,5,0", n,
                     tag_seen, spec_seen);
        end
        // Squash and resolve together: squash must win.
        @(negedge clock);
        set_issue(FuncMul, 32'd5, 32'd6, 5'd6, 1'b1);
        #1;
        @(negedge clock);
        idle_inputs();
        bus.squash  = 1'b1;
        bus.resolve = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (bus.out_valid) n++;
        end
        checks++;
        if (n != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL squash_beats_resolve got outputs=%0d busy=%b want 0,0", n, bus.busy);
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            set_issue(FuncMulhu, $urandom, $urandom, 5'(i + 20), 1'b0);
            #1;
        end
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got busy=%b in_ready=%b out_valid=%b want 0,1,0",
                     bus.busy, bus.in_ready, bus.out_valid);
        end
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            if (bus.out_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL midreset_no_output got %0d outputs want 0", n);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t keep[$];
        ent_t e;
        for (int cyc = 0; cyc < 430; cyc++) begin
            @(negedge clock);
            idle_inputs();
            if (cyc < 400) begin
                bus.in_valid  = ($urandom_range(0, 3) != 0);
                bus.in_func   = mult_func_e'($urandom_range(0, 3));
                bus.in_opa    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                bus.in_opb    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                bus.in_tag    = 5'($urandom);
                bus.in_spec   = 1'($urandom_range(0, 1));
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.squash    = ($urandom_range(0, 15) == 0);
                bus.resolve   = ($urandom_range(0, 7) == 0);
            end
            #1;
            checks++;
            if (bus.busy !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_busy cyc%0d got %b want %b", cyc, bus.busy, q.size() != 0);
            end
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++;
                $display("FAIL rand_in_ready cyc%0d got %b want %b", cyc, bus.in_ready,
                         !bus.out_valid || bus.out_ready);
            end
            if (bus.out_valid && bus.out_ready && !(bus.squash && bus.out_spec)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious cyc%0d got tag=%0d want no output", cyc,
                             bus.out_tag);
                end else begin
                    e = q.pop_front();
                    if (bus.out_tag !== e.tag || bus.out_value !== e.val ||
                        bus.out_spec !== e.spec) begin
                        errors++;
                        $display("FAIL rand_retire cyc%0d got tag=%0d val=%h spec=%b want %0d %h %b",
                                 cyc, bus.out_tag, bus.out_value, bus.out_spec, e.tag, e.val,
                                 e.spec);
                    end
                end
            end
            if (bus.squash) begin
                keep = {};
                foreach (q[k]) if (!q[k].spec) keep.push_back(q[k]);
                q = keep;
            end else if (bus.resolve) begin
                foreach (q[k]) q[k].spec = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && !(bus.squash && bus.in_spec)) begin
                e.tag  = bus.in_tag;
                e.spec = bus.in_spec && !bus.resolve;
                e.val  = ref_mul(bus.in_func, bus.in_opa, bus.in_opb);
                q.push_back(e);
            end
        end
        checks++;
        if (q.size() != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain got pending=%0d busy=%b want 0,0", q.size(), bus.busy);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_latency();
        test_funcs();
        test_back_to_back();
        test_squash();
        test_resolve();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
